// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin EXU/LSU writeback arbiter with busy scoreboard
module regfile_wb_arbiter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [4:0]       issue_rd,
  output logic             issue_ready,
  input  logic [4:0]       rs1_addr,
  input  logic [4:0]       rs2_addr,
  output logic             rs1_busy,
  output logic             rs2_busy,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic [WIDTH-1:0] ex_data,
  output logic             ex_ready,
  input  logic             ls_valid,
  input  logic [4:0]       ls_rd,
  input  logic [WIDTH-1:0] ls_data,
  output logic             ls_ready,
  input  logic             flush,
  output logic             rf_we,
  output logic [4:0]       rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             err
);
  logic [31:0]      busy_q, busy_d;
  logic             last_q, last_d;
  logic             rf_we_q, rf_we_d, err_q, err_d;
  logic [4:0]       rf_waddr_q, rf_waddr_d;
  logic [WIDTH-1:0] rf_wdata_q, rf_wdata_d;
  logic             gnt_ex, gnt_ls, acc;
  logic [4:0]       w_rd;
  logic [WIDTH-1:0] w_data;

  assign issue_ready = ~flush & ~busy_q[issue_rd];
  assign rs1_busy    = busy_q[rs1_addr];
  assign rs2_busy    = busy_q[rs2_addr];
  assign ex_ready    = gnt_ex;
  assign ls_ready    = gnt_ls;
  assign rf_we       = rf_we_q;
  assign rf_waddr    = rf_waddr_q;
  assign rf_wdata    = rf_wdata_q;
  assign err         = err_q;

  // Arbitration (last_q=1 means LSU won last), output register and scoreboard next state
  always_comb begin
    gnt_ex     = ex_valid & (~ls_valid | last_q);
    gnt_ls     = ls_valid & ~gnt_ex;
    acc        = gnt_ex | gnt_ls;
    w_rd       = gnt_ex ? ex_rd : ls_rd;
    w_data     = gnt_ex ? ex_data : ls_data;
    last_d     = acc ? gnt_ls : last_q;
    rf_we_d    = acc & (w_rd != 5'd0);
    rf_waddr_d = acc ? w_rd : rf_waddr_q;
    rf_wdata_d = acc ? w_data : rf_wdata_q;
    err_d      = err_q | (acc & (w_rd != 5'd0) & ~busy_q[w_rd]);
    busy_d     = busy_q;
    if (rf_we_q) busy_d[rf_waddr_q] = 1'b0;
    if (issue_valid & issue_ready) busy_d[issue_rd] = 1'b1;
    if (flush) busy_d = '0;
    busy_d[0]  = 1'b0;
  end

  // State registers; reset discards any pending write immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= '0;
      last_q     <= 1'b1;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      err_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      last_q     <= last_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      err_q      <= err_d;
    end
  end
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb_regfile_wb_arbiter: directed scoreboard bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;
  logic        clk = 1'b0, rst_n;
  logic        issue_valid, issue_ready, rs1_busy, rs2_busy;
  logic [4:0]  issue_rd, rs1_addr, rs2_addr, ex_rd, ls_rd, rf_waddr;
  logic        ex_valid, ex_ready, ls_valid, ls_ready, flush, rf_we, err;
  logic [31:0] ex_data, ls_data, rf_wdata;
  int          checks = 0, errors = 0, cyc_n = 0;
  logic        lg = 1'b1;

  typedef struct { int c; logic [4:0] a; logic [31:0] d; } exp_t;
  exp_t q[$];

  regfile_wb_arbiter #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_ready(issue_ready), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_data(ex_data), .ex_ready(ex_ready), .ls_valid(ls_valid), .ls_rd(ls_rd),
    .ls_data(ls_data), .ls_ready(ls_ready), .flush(flush), .rf_we(rf_we),
    .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic iss(input logic [4:0] rd);
    issue_valid = 1'b1;
    issue_rd = rd;
    #2 chk("issue_ready", {31'b0, issue_ready}, 1);
    cyc();
    issue_valid = 1'b0;
  endtask

  task automatic xfer(input logic ev, input logic [4:0] er, input logic [31:0] ed,
                      input logic lv, input logic [4:0] lr, input logic [31:0] ld);
    logic e_ex, e_ls;
    logic [4:0] ra;
    ex_valid = ev; ex_rd = er; ex_data = ed;
    ls_valid = lv; ls_rd = lr; ls_data = ld;
    #2;
    e_ex = ev & (~lv | lg);
    e_ls = lv & ~e_ex;
    chk("ex_ready", {31'b0, ex_ready}, {31'b0, e_ex});
    chk("ls_ready", {31'b0, ls_ready}, {31'b0, e_ls});
    if (e_ex | e_ls) begin
      lg = e_ls;
      ra = e_ex ? er : lr;
      if (ra != 5'd0) q.push_back('{cyc_n + 1, ra, e_ex ? ed : ld});
    end
    cyc();
    ex_valid = 1'b0;
    ls_valid = 1'b0;
  endtask

  // Scoreboard: every cycle rf_we must match whether a write is due now
  always @(negedge clk) begin
    logic due;
    due = 1'b0;
    if (q.size() > 0) due = (q[0].c == cyc_n);
    chk("rf_we", {31'b0, rf_we}, {31'b0, due});
    if (due) begin
      chk("rf_waddr", {27'b0, rf_waddr}, {27'b0, q[0].a});
      chk("rf_wdata", rf_wdata, q[0].d);
      void'(q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; issue_valid = 1'b0; issue_rd = 5'd5;
    rs1_addr = 5'd5; rs2_addr = 5'd31;
    ex_valid = 1'b1; ex_rd = 5'd0; ex_data = 32'hA; ls_valid = 1'b1; ls_rd = 5'd0; ls_data = 32'hB;
    #2;
    chk("rst_rf_we", {31'b0, rf_we}, 0);
    chk("rst_waddr", {27'b0, rf_waddr}, 0);
    chk("rst_wdata", rf_wdata, 0);
    chk("rst_issue_ready5", {31'b0, issue_ready}, 1);
    issue_rd = 5'd31;
    #1 chk("rst_issue_ready31", {31'b0, issue_ready}, 1);
    chk("rst_rs1_busy", {31'b0, rs1_busy}, 0);
    chk("rst_rs2_busy", {31'b0, rs2_busy}, 0);
    chk("rst_err", {31'b0, err}, 0);
    cyc(); cyc();
    rst_n = 1'b1;
    xfer(1, 5'd0, 32'hA, 1, 5'd0, 32'hB);
    // single write
    iss(5'd5);
    rs1_addr = 5'd5; issue_valid = 1'b1; issue_rd = 5'd5;
    #2 chk("sw_rs1_busy", {31'b0, rs1_busy}, 1);
    chk("sw_issue_waw", {31'b0, issue_ready}, 0);
    cyc();
    issue_valid = 1'b0;
    cyc();
    xfer(1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0);
    #2 chk("sw_rs1_busy_c4", {31'b0, rs1_busy}, 1);
    cyc();
    rs2_addr = 5'd5;
    #2 chk("sw_rs1_clear", {31'b0, rs1_busy}, 0);
    chk("sw_rs2_clear", {31'b0, rs2_busy}, 0);
    // x0 write from LSU
    xfer(0, 5'd0, 32'h0, 1, 5'd0, 32'h1111);
    #2 chk("x0_err", {31'b0, err}, 0);
    // contention
    for (int r = 1; r <= 5; r++) iss(r[4:0]);
    xfer(1, 5'd1, 32'h100, 1, 5'd2, 32'h200);
    xfer(1, 5'd3, 32'h300, 1, 5'd2, 32'h200);
    xfer(1, 5'd3, 32'h300, 1, 5'd4, 32'h400);
    xfer(1, 5'd5, 32'h500, 1, 5'd4, 32'h400);
    xfer(1, 5'd5, 32'h500, 0, 5'd0, 32'h0);
    cyc();
    for (int r = 1; r <= 5; r++) begin
      rs1_addr = r[4:0];
      #1 chk("ct_busy_clear", {31'b0, rs1_busy}, 0);
    end
    chk("ct_err", {31'b0, err}, 0);
    // spurious write to a non-busy register
    xfer(1, 5'd7, 32'h77, 0, 5'd0, 32'h0);
    #2 chk("sp_err", {31'b0, err}, 1);
    cyc();
    // flush with a write already in flight
    iss(5'd3);
    iss(5'd9);
    xfer(1, 5'd3, 32'h333, 0, 5'd0, 32'h0);
    flush = 1'b1; issue_valid = 1'b1; issue_rd = 5'd12; rs1_addr = 5'd9;
    #2 chk("fl_issue_ready", {31'b0, issue_ready}, 0);
    chk("fl_busy9_during", {31'b0, rs1_busy}, 1);
    cyc();
    flush = 1'b0; issue_valid = 1'b0; issue_rd = 5'd9; rs2_addr = 5'd3;
    #2 chk("fl_busy9", {31'b0, rs1_busy}, 0);
    chk("fl_busy3", {31'b0, rs2_busy}, 0);
    chk("fl_issue_ready9", {31'b0, issue_ready}, 1);
    rs1_addr = 5'd12;
    #1 chk("fl_no_issue12", {31'b0, rs1_busy}, 0);
    chk("fl_err_sticky", {31'b0, err}, 1);
    cyc();
    // reset mid-operation
    iss(5'd6);
    xfer(1, 5'd6, 32'h666, 0, 5'd0, 32'h0);
    q.delete();
    rs1_addr = 5'd6;
    #1 chk("mr_rf_we_before", {31'b0, rf_we}, 1);
    chk("mr_busy_before", {31'b0, rs1_busy}, 1);
    rst_n = 1'b0;
    #1 chk("mr_rf_we_async", {31'b0, rf_we}, 0);
    chk("mr_busy_async", {31'b0, rs1_busy}, 0);
    chk("mr_err", {31'b0, err}, 0);
    ex_valid = 1'b1; ex_rd = 5'd0; ls_valid = 1'b1; ls_rd = 5'd0;
    cyc(); cyc();
    rst_n = 1'b1;
    lg = 1'b1;
    xfer(1, 5'd0, 32'hC, 1, 5'd0, 32'hD);
    cyc(); cyc();
    chk("q_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
